cell_beat_serializer: RTL and testbench



---
 rtl/cell_pkg.sv | 14 +
 rtl/cell_pos_counter.sv | 54 +++++
 rtl/cell_beat_serializer.sv | 108 ++++++++++
 tb/tb_cell_beat_serializer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cell_pkg.sv
// Shared cell-stream definitions used by the fetch stage, the beat serializer and HOG.
package cell_pkg;

    localparam int CELL_WIDTH = 768;
    localparam int CELL_COL   = 40;
    localparam int CELL_ROW   = 30;
    localparam int CELL_NUM   = CELL_COL * CELL_ROW;

    typedef enum logic {
        SER_EMPTY_ST = 1'b0,
        SER_SHIFT_ST = 1'b1
    } ser_state_e;

endpackage

// File: rtl/cell_pos_counter.sv
// Frame position tracker: column/row counters advanced once per finished cell,
// with end-of-row and end-of-frame compares.
module cell_pos_counter #(
    parameter int  CELL_COL = 40,
    parameter int  CELL_ROW = 30,
    localparam int COL_W    = $clog2(CELL_COL),
    localparam int ROW_W    = $clog2(CELL_ROW)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv_i,
    output logic [COL_W-1:0] col_o,
    output logic [ROW_W-1:0] row_o,
    output logic             eol_o,
    output logic             frame_last_o
);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             col_end, row_end;

    assign col_end = (col_q == COL_W'(CELL_COL - 1));
    assign row_end = (row_q == ROW_W'(CELL_ROW - 1));

    // Wrap by explicit compare so non-power-of-two frame sizes work.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (adv_i) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col_o        = col_q;
    assign row_o        = row_q;
    assign eol_o        = col_end;
    assign frame_last_o = col_end && row_end;

endmodule

// File: rtl/cell_beat_serializer.sv
// Splits each accepted cell into BEAT_NUM beats (LSB slice first) tagged with cell/row/frame markers.
// Optional macro CELL_SER_POS_EN drives fwd_cell_x_o/fwd_cell_y_o with the cell position.
module cell_beat_serializer #(
    parameter int  CELL_WIDTH = cell_pkg::CELL_WIDTH,
    parameter int  BEAT_NUM   = 8,
    parameter int  CELL_COL   = cell_pkg::CELL_COL,
    parameter int  CELL_ROW   = cell_pkg::CELL_ROW,
    localparam int BEAT_WIDTH = CELL_WIDTH / BEAT_NUM,
    localparam int BEAT_W     = $clog2(BEAT_NUM),
    localparam int COL_W      = $clog2(CELL_COL),
    localparam int ROW_W      = $clog2(CELL_ROW)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CELL_WIDTH-1:0] bwd_cell_data_i,
    input  logic                  bwd_cell_valid_i,
    output logic                  bwd_cell_ready_o,
    output logic [BEAT_WIDTH-1:0] fwd_beat_data_o,
    output logic                  fwd_beat_valid_o,
    input  logic                  fwd_beat_ready_i,
    output logic                  fwd_beat_last_o,
    output logic                  fwd_cell_eol_o,
    output logic                  fwd_frame_last_o,
    output logic [COL_W-1:0]      fwd_cell_x_o,
    output logic [ROW_W-1:0]      fwd_cell_y_o
);
    import cell_pkg::*;

    ser_state_e                           state_q, state_d;
    logic [CELL_WIDTH-1:0]                cell_q, cell_d;
    logic [BEAT_W-1:0]                    beat_cnt_q, beat_cnt_d;
    logic [BEAT_NUM-1:0][BEAT_WIDTH-1:0]  beats;
    logic                                 shifting, last_beat, in_hs, out_hs, adv;
    logic [COL_W-1:0]                     col_cnt;
    logic [ROW_W-1:0]                     row_cnt;
    logic                                 eol, frame_last;

    assign shifting  = (state_q == SER_SHIFT_ST);
    assign last_beat = (beat_cnt_q == BEAT_W'(BEAT_NUM - 1));
    assign out_hs    = shifting && fwd_beat_ready_i;
    assign adv       = out_hs && last_beat;

    // Refill during the final beat handshake so cells stream without a bubble.
    assign bwd_cell_ready_o = (state_q == SER_EMPTY_ST) || adv;
    assign in_hs            = bwd_cell_valid_i && bwd_cell_ready_o;

    always_comb begin
        state_d    = state_q;
        cell_d     = cell_q;
        beat_cnt_d = beat_cnt_q;
        if (out_hs) begin
            if (last_beat) begin
                state_d = SER_EMPTY_ST;
            end else begin
                beat_cnt_d = beat_cnt_q + BEAT_W'(1);
            end
        end
        if (in_hs) begin
            state_d    = SER_SHIFT_ST;
            cell_d     = bwd_cell_data_i;
            beat_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SER_EMPTY_ST;
            cell_q     <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cell_q     <= cell_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    cell_pos_counter #(
        .CELL_COL (CELL_COL),
        .CELL_ROW (CELL_ROW)
    ) u_pos (
        .clk          (clk),
        .rst          (rst),
        .adv_i        (adv),
        .col_o        (col_cnt),
        .row_o        (row_cnt),
        .eol_o        (eol),
        .frame_last_o (frame_last)
    );

    assign beats            = cell_q;
    assign fwd_beat_valid_o = shifting;
    assign fwd_beat_data_o  = shifting ? beats[beat_cnt_q] : '0;
    assign fwd_beat_last_o  = shifting && last_beat;
    assign fwd_cell_eol_o   = shifting && eol;
    assign fwd_frame_last_o = shifting && frame_last;

`ifdef CELL_SER_POS_EN
    assign fwd_cell_x_o = shifting ? col_cnt : '0;
    assign fwd_cell_y_o = shifting ? row_cnt : '0;
`else
    // Counters still feed the markers; the position itself is not exported.
    logic unused_pos;
    assign unused_pos   = ^{col_cnt, row_cnt};
    assign fwd_cell_x_o = '0;
    assign fwd_cell_y_o = '0;
`endif

endmodule

// File: tb/tb_cell_beat_serializer.sv
// Scoreboard bench for cell_beat_serializer: random cells/back-pressure against a frame-position model.
module tb_cell_beat_serializer;
    import cell_pkg::*;

    localparam int BN = 8;
    localparam int BW = CELL_WIDTH / BN;
    localparam int CW = $clog2(CELL_COL);
    localparam int RW = $clog2(CELL_ROW);

    typedef struct packed {
        logic [BW-1:0] data;
        logic          last;
        logic          eol;
        logic          flast;
        logic [CW-1:0] x;
        logic [RW-1:0] y;
    } beat_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [CELL_WIDTH-1:0] bwd_cell_data_i = '0;
    logic                  bwd_cell_valid_i = 1'b0;
    logic                  bwd_cell_ready_o;
    logic [BW-1:0]         fwd_beat_data_o;
    logic                  fwd_beat_valid_o;
    logic                  fwd_beat_ready_i = 1'b0;
    logic                  fwd_beat_last_o;
    logic                  fwd_cell_eol_o;
    logic                  fwd_frame_last_o;
    logic [CW-1:0]         fwd_cell_x_o;
    logic [RW-1:0]         fwd_cell_y_o;

    beat_t exp_q[$];
    int    tests = 0;
    int    fails = 0;
    int    cell_idx = 0;
    int    popped = 0;
    int    eol_hs = 0;
    int    flast_hs = 0;
    bit    acc_flag = 0;
    bit    abort = 0;

    cell_beat_serializer #(.BEAT_NUM(BN)) dut (
        .clk              (clk),
        .rst              (rst),
        .bwd_cell_data_i  (bwd_cell_data_i),
        .bwd_cell_valid_i (bwd_cell_valid_i),
        .bwd_cell_ready_o (bwd_cell_ready_o),
        .fwd_beat_data_o  (fwd_beat_data_o),
        .fwd_beat_valid_o (fwd_beat_valid_o),
        .fwd_beat_ready_i (fwd_beat_ready_i),
        .fwd_beat_last_o  (fwd_beat_last_o),
        .fwd_cell_eol_o   (fwd_cell_eol_o),
        .fwd_frame_last_o (fwd_frame_last_o),
        .fwd_cell_x_o     (fwd_cell_x_o),
        .fwd_cell_y_o     (fwd_cell_y_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cell n of the frame sits at column n%COL, row (n/COL)%ROW.
    function automatic void push_cell(input logic [CELL_WIDTH-1:0] c);
        int col;
        int row;
        col = cell_idx % CELL_COL;
        row = (cell_idx / CELL_COL) % CELL_ROW;
        for (int k = 0; k < BN; k++) begin
            beat_t b;
            b.data  = c[k*BW +: BW];
            b.last  = (k == BN - 1);
            b.eol   = (col == CELL_COL - 1);
            b.flast = (col == CELL_COL - 1) && (row == CELL_ROW - 1);
`ifdef CELL_SER_POS_EN
            b.x = CW'(col);
            b.y = RW'(row);
`else
            b.x = '0;
            b.y = '0;
`endif
            exp_q.push_back(b);
        end
        cell_idx++;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("valid", fwd_beat_valid_o, exp_q.size() != 0);
            chk("ready", bwd_cell_ready_o,
                (exp_q.size() == 0) || (exp_q.size() == 1 && fwd_beat_ready_i));
            if (fwd_beat_valid_o && exp_q.size() != 0) begin
                beat_t e;
                e = exp_q[0];
                chk("beat_data", fwd_beat_data_o, e.data);
                chk("beat_last", fwd_beat_last_o, e.last);
                chk("cell_eol", fwd_cell_eol_o, e.eol);
                chk("frame_last", fwd_frame_last_o, e.flast);
                chk("cell_x", fwd_cell_x_o, e.x);
                chk("cell_y", fwd_cell_y_o, e.y);
            end
            if (fwd_beat_valid_o && fwd_beat_ready_i && exp_q.size() != 0) begin
                if (fwd_cell_eol_o) eol_hs++;
                if (fwd_frame_last_o) flast_hs++;
                void'(exp_q.pop_front());
                popped++;
            end
            if (bwd_cell_valid_i && bwd_cell_ready_o) begin
                push_cell(bwd_cell_data_i);
                acc_flag = 1;
            end
        end
    end

    function automatic logic [CELL_WIDTH-1:0] rand_cell();
        logic [CELL_WIDTH-1:0] c;
        for (int i = 0; i < CELL_WIDTH / 32; i++) c[i*32 +: 32] = $urandom();
        return c;
    endfunction

    function automatic logic [CELL_WIDTH-1:0] byte_pattern();
        logic [CELL_WIDTH-1:0] c;
        for (int i = 0; i < CELL_WIDTH / 8; i++) c[i*8 +: 8] = 8'(i);
        return c;
    endfunction

    task automatic run_cells(input int n, input int pv, input int pr, input bit directed);
        int sent;
        int guard;
        sent  = 0;
        guard = 0;
        bwd_cell_valid_i = 1'b0;
        while (sent < n && guard < n * 40 + 100 && !abort) begin
            @(posedge clk);
            #1;
            if (abort) break;
            guard++;
            if (acc_flag) begin
                acc_flag = 0;
                sent++;
                bwd_cell_valid_i = 1'b0;
            end
            fwd_beat_ready_i = ($urandom_range(99) < pr);
            if (sent < n && !bwd_cell_valid_i && $urandom_range(99) < pv) begin
                bwd_cell_valid_i = 1'b1;
                bwd_cell_data_i  = directed ? byte_pattern() : rand_cell();
            end
        end
        if (!abort) begin
            bwd_cell_valid_i = 1'b0;
            chk("feed_done", sent == n, 1'b1);
        end
        fwd_beat_ready_i = 1'b1;
    endtask

    task automatic drain();
        int g;
        g = 0;
        bwd_cell_valid_i = 1'b0;
        while ((exp_q.size() != 0 || fwd_beat_valid_o) && g < 2000) begin
            @(posedge clk);
            #1;
            fwd_beat_ready_i = 1'($urandom_range(1));
            g++;
        end
        chk("drain_done", exp_q.size() == 0 && !fwd_beat_valid_o, 1'b1);
        fwd_beat_ready_i = 1'b0;
    endtask

    task automatic clear_model();
        exp_q.delete();
        cell_idx = 0;
        popped   = 0;
        acc_flag = 0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, fwd_beat_valid_o, 1'b0);
        chk({tag, "_ready"}, bwd_cell_ready_o, 1'b1);
        chk({tag, "_data"}, fwd_beat_data_o, '0);
        chk({tag, "_marks"}, {fwd_beat_last_o, fwd_cell_eol_o, fwd_frame_last_o}, 3'b000);
        chk({tag, "_xy"}, {fwd_cell_x_o, fwd_cell_y_o}, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        @(posedge clk);
        #2;
        rst = 1'b0;

        run_cells(1, 100, 100, 1'b1);
        drain();
        run_cells(2, 100, 100, 1'b0);
        drain();
        run_cells(1200, 75, 50, 1'b0);
        drain();
        chk("eol_beat_count", eol_hs, 30 * BN);
        chk("frame_last_beat_count", flast_hs, BN);

        @(posedge clk);
        #2;
        rst = 1'b1;
        clear_model();
        @(posedge clk);
        #2;
        rst = 1'b0;

        fork
            run_cells(60, 80, 50, 1'b0);
            begin
                int g;
                g = 0;
                while (popped != 45 * BN + 3 && g < 5000) begin
                    @(posedge clk);
                    #2;
                    g++;
                end
                chk("reach_cell45_beat3", popped, 45 * BN + 3);
                rst = 1'b1;
                abort = 1;
                bwd_cell_valid_i = 1'b0;
                #1;
                check_idle("async_rst");
            end
        join
        clear_model();
        @(posedge clk);
        #2;
        abort = 0;
        rst = 1'b0;

        run_cells(3, 100, 100, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
